// File: rtl/qam_rx_pkg.sv
// Shared definitions for the QPSK/16QAM receive demapper.
// Mode encodings, bits-per-symbol helper, Gray level codes and the default pilot.
// No logic here; the package is imported by the slicer and the demapper top.
package qam_rx_pkg;

  localparam logic MOD_QPSK  = 1'b0;
  localparam logic MOD_QAM16 = 1'b1;

  // 16QAM per-axis Gray codes, from most negative level to most positive
  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  localparam logic [31:0] PILOT_WORD_DEF = 32'hF0F0_3C3C;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  function automatic logic [2:0] bps(input logic mod_type);
    return (mod_type == MOD_QAM16) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/qam_slicer.sv
// Per-axis hard decision: maps one signed sample to its 2-bit level code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
module qam_slicer
  import qam_rx_pkg::*;
#(
  parameter int SCALE = 65536
) (
  input  logic signed [31:0] x_i,
  input  logic               mod_type_i,
  output logic [1:0]         code_o
);

  localparam logic signed [31:0] TWO_S = 32'(2 * SCALE);

  // Ties resolve upward: a sample exactly on a threshold takes the higher level
  always_comb begin
    code_o = 2'b00;
    if (mod_type_i == MOD_QPSK) begin
      code_o = {1'b0, (x_i >= 0)};
    end else if (x_i < -TWO_S) begin
      code_o = LVL_M3;
    end else if (x_i < 0) begin
      code_o = LVL_M1;
    end else if (x_i < TWO_S) begin
      code_o = LVL_P1;
    end else begin
      code_o = LVL_P3;
    end
  end

endmodule

// File: rtl/qam_symbol_demap.sv
// Slices I/Q symbols, hunts for the pilot word, then serialises data bits MSB-first.
// Latency: a data symbol accepted in cycle N shows its MSB in cycle N+1.
// Backpressure: sym_ready drops while a loaded symbol still has unsent bits; bit_out holds while bit_ready is low.
// Optional out-of-range counter on err_cnt when QAM_DEMAP_ERR_CNT_EN is defined.
module qam_symbol_demap
  import qam_rx_pkg::*;
#(
  parameter int          SCALE      = 65536,
  parameter logic [31:0] PILOT_WORD = PILOT_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mod_type,
  input  logic signed [31:0] sym_i,
  input  logic signed [31:0] sym_q,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               frame_lock
`ifdef QAM_DEMAP_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  state_e      state_q;
  logic        mod_q;
  logic [31:0] win_q;
  logic [5:0]  fill_q;
  logic [3:0]  sh_q;
  logic [1:0]  cnt_q;
  logic        vld_q;

  logic [1:0]  i_code, q_code;
  logic        mod_chg, last_bit, bit_hs, sym_acc;
  logic [31:0] win_d;
  logic [5:0]  fill_sum, fill_d;
  logic [3:0]  sh_load;

  qam_slicer #(.SCALE(SCALE)) u_slice_i (.x_i(sym_i), .mod_type_i(mod_q), .code_o(i_code));
  qam_slicer #(.SCALE(SCALE)) u_slice_q (.x_i(sym_q), .mod_type_i(mod_q), .code_o(q_code));

  // Handshake, window shift and serialiser load values
  always_comb begin
    mod_chg   = (mod_type != mod_q);
    last_bit  = ({1'b0, cnt_q} == (bps(mod_q) - 3'd1));
    bit_hs    = vld_q && bit_ready;
    // Hold off symbols during a mode switch so none is silently dropped
    sym_ready = rst_n && !mod_chg &&
                ((state_q == ST_HUNT) || !vld_q || (bit_hs && last_bit));
    sym_acc   = sym_valid && sym_ready;
    win_d     = (mod_q == MOD_QAM16) ? {win_q[27:0], i_code, q_code}
                                     : {win_q[29:0], i_code[0], q_code[0]};
    fill_sum  = fill_q + {3'b000, bps(mod_q)};
    fill_d    = (fill_sum >= 6'd32) ? 6'd32 : fill_sum;
    sh_load   = (mod_q == MOD_QAM16) ? {i_code, q_code}
                                     : {i_code[0], q_code[0], 2'b00};
  end

  assign bit_out    = sh_q[3];
  assign bit_valid  = vld_q;
  assign frame_lock = (state_q == ST_DATA);

  // Pilot hunt / data serialisation state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      mod_q   <= MOD_QPSK;
      win_q   <= '0;
      fill_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else if (mod_chg) begin
      mod_q   <= mod_type;
      state_q <= ST_HUNT;
      win_q   <= '0;
      fill_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (sym_acc) begin
            win_q  <= win_d;
            fill_q <= fill_d;
            if ((fill_d == 6'd32) && (win_d == PILOT_WORD)) begin
              state_q <= ST_DATA;
            end
          end
        end
        default: begin
          if (sym_acc) begin
            sh_q  <= sh_load;
            cnt_q <= '0;
            vld_q <= 1'b1;
          end else if (bit_hs) begin
            if (last_bit) begin
              vld_q <= 1'b0;
              sh_q  <= '0;
              cnt_q <= '0;
            end else begin
              sh_q  <= {sh_q[2:0], 1'b0};
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef QAM_DEMAP_ERR_CNT_EN
  localparam logic signed [31:0] FOUR_S = 32'(4 * SCALE);

  logic        oor;
  logic [15:0] err_q;

  assign oor = (sym_i > FOUR_S) || (sym_i < -FOUR_S) ||
               (sym_q > FOUR_S) || (sym_q < -FOUR_S);
  assign err_cnt = err_q;

  // Saturating count of accepted symbols beyond the outer constellation ring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (sym_acc && oor && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qam_symbol_demap.sv
module tb_qam_symbol_demap;

  localparam int S = 65536;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mod_type = 1'b0;
  logic signed [31:0] sym_i = '0;
  logic signed [31:0] sym_q = '0;
  logic               sym_valid = 1'b0;
  logic               sym_ready;
  logic               bit_out;
  logic               bit_valid;
  logic               bit_ready = 1'b1;
  logic               frame_lock;
`ifdef QAM_DEMAP_ERR_CNT_EN
  logic [15:0]        err_cnt;
`endif

  qam_symbol_demap dut (
    .clk(clk), .rst_n(rst_n), .mod_type(mod_type),
    .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .frame_lock(frame_lock)
`ifdef QAM_DEMAP_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #45 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  logic exp_q[$];
  logic [31:0] pw = 32'hF0F0_3C3C;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor: every bit handshake pops one expected bit
  always @(negedge clk) begin
    logic e;
    if (rst_n && bit_valid && bit_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_bit actual %0b required none (cycle %0d)", bit_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bit_out !== e) begin
          errors = errors + 1;
          $display("FAIL bit_out actual %0b required %0b (cycle %0d)", bit_out, e, cyc);
        end
      end
      hs_cnt = hs_cnt + 1;
      last_hs_cyc = cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic signed [31:0] lvl(input logic [1:0] c);
    case (c)
      2'b00:   return -3 * S;
      2'b01:   return -S;
      2'b11:   return S;
      default: return 3 * S;
    endcase
  endfunction

  task automatic send_sym(input logic signed [31:0] i, input logic signed [31:0] q);
    int n;
    @(negedge clk);
    sym_i = i; sym_q = q; sym_valid = 1'b1;
    n = 0;
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sym_accept", {31'd0, sym_ready}, 32'd1);
    @(posedge clk);
    #1 sym_valid = 1'b0;
  endtask

  task automatic send_pilot_qpsk(input int first, input int cnt);
    for (int k = first; k < first + cnt; k++) begin
      send_sym(pw[31 - 2*k] ? S : -S, pw[30 - 2*k] ? S : -S);
    end
  endtask

  task automatic send_pilot_qam(input int first, input int cnt);
    logic [3:0] nib;
    for (int k = first; k < first + cnt; k++) begin
      nib = pw[31 - 4*k -: 4];
      send_sym(lvl(nib[3:2]), lvl(nib[1:0]));
    end
  endtask

  task automatic push4(input logic [3:0] b);
    for (int k = 3; k >= 0; k--) exp_q.push_back(b[k]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic signed [31:0] bvals [6];
  logic [1:0]         bcodes[6];
  int rel_cyc, hs0;

  initial begin
    bvals[0] = -2*S - 1; bcodes[0] = 2'b00;
    bvals[1] = -2*S;     bcodes[1] = 2'b01;
    bvals[2] = -1;       bcodes[2] = 2'b01;
    bvals[3] = 0;        bcodes[3] = 2'b11;
    bvals[4] = 2*S - 1;  bcodes[4] = 2'b11;
    bvals[5] = 2*S;      bcodes[5] = 2'b10;

    // Reset state
    #20;
    chk("rst_sym_ready", {31'd0, sym_ready}, 32'd0);
    chk("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    chk("rst_bit_out", {31'd0, bit_out}, 32'd0);
    chk("rst_frame_lock", {31'd0, frame_lock}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("hunt_sym_ready", {31'd0, sym_ready}, 32'd1);

    // QPSK lock and data
    send_pilot_qpsk(0, 15);
    chk("qpsk_no_lock_15", {31'd0, frame_lock}, 32'd0);
    send_pilot_qpsk(15, 1);
    chk("qpsk_lock", {31'd0, frame_lock}, 32'd1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    send_sym(S, -S);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    send_sym(-S, S);
    wait_drain();
    tick();
    chk("qpsk_idle_valid", {31'd0, bit_valid}, 32'd0);

    // Switch to 16QAM; false pilot then a real one
    mod_type = 1'b1;
    tick();
    chk("modchg_unlock", {31'd0, frame_lock}, 32'd0);
    send_pilot_qam(0, 7);
    send_sym(S, S);
    chk("false_pilot", {31'd0, frame_lock}, 32'd0);
    send_pilot_qam(0, 7);
    chk("qam_no_lock_7", {31'd0, frame_lock}, 32'd0);
    send_pilot_qam(7, 1);
    chk("qam_lock", {31'd0, frame_lock}, 32'd1);

    // Slicer threshold boundaries on I, Q = 0 slices to 11
    for (int k = 0; k < 6; k++) begin
      push4({bcodes[k], 2'b11});
      send_sym(bvals[k], 0);
    end
    wait_drain();

    // Backpressure: bits held, no symbol taken, then gapless streaming
    tick();
    bit_ready = 1'b0;
    push4(4'b1001);
    send_sym(3*S, -S);
    sym_i = -3*S; sym_q = S; sym_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_sym_ready", {31'd0, sym_ready}, 32'd0);
      chk("bp_bit_valid", {31'd0, bit_valid}, 32'd1);
      chk("bp_bit_out", {31'd0, bit_out}, 32'd1);
      tick();
    end
    bit_ready = 1'b1;
    rel_cyc = cyc;
    hs0 = hs_cnt;
    push4(4'b0011);
    send_sym(-3*S, S);
    push4(4'b1110);
    send_sym(S, 3*S);
    wait_drain();
    chk("bp_hs_count", hs_cnt - hs0, 32'd12);
    chk("bp_no_gap", last_hs_cyc - rel_cyc, 32'd11);

    // Mode toggle after two of four bits
    tick();
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    send_sym(3*S, -3*S);
    @(posedge clk);
    @(posedge clk);
    #1 bit_ready = 1'b0; mod_type = 1'b0;
    tick();
    chk("toggle_bit_valid", {31'd0, bit_valid}, 32'd0);
    chk("toggle_frame_lock", {31'd0, frame_lock}, 32'd0);
    bit_ready = 1'b1;
    wait_drain();
    send_pilot_qpsk(0, 15);
    chk("relock_not_early", {31'd0, frame_lock}, 32'd0);
    send_pilot_qpsk(15, 1);
    chk("relock", {31'd0, frame_lock}, 32'd1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    send_sym(S, S);
    wait_drain();

    // Reset mid-serialisation
    tick();
    bit_ready = 1'b0;
    send_sym(S, -S);
    tick();
    chk("pre_rst_valid", {31'd0, bit_valid}, 32'd1);
    chk("pre_rst_bit", {31'd0, bit_out}, 32'd1);
    #10 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bit_valid}, 32'd0);
    chk("async_rst_bit", {31'd0, bit_out}, 32'd0);
    chk("async_rst_lock", {31'd0, frame_lock}, 32'd0);
    chk("async_rst_ready", {31'd0, sym_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bit_ready = 1'b1;
    #1 chk("post_rst_ready", {31'd0, sym_ready}, 32'd1);

`ifdef QAM_DEMAP_ERR_CNT_EN
    chk("err_cnt_reset", {16'd0, err_cnt}, 32'd0);
    send_sym(4*S + 1, 0);
    send_sym(4*S + 1, 0);
    send_sym(4*S + 1, 0);
    send_sym(4*S, 0);
    chk("err_cnt", {16'd0, err_cnt}, 32'd3);
`endif

    repeat (4) @(posedge clk);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_symbol_demap.md
# qam_symbol_demap

Receive-side counterpart of the QPSK/16QAM transmit chain. Accepts baseband I/Q symbol decisions at one sample per symbol and slices them to the nearest constellation point. It hunts for the pilot word to gain frame lock, then serialises the data bits MSB-first onto a ready/valid bitstream. It sits between the receive matched filter/symbol-timing stage and the bit-level consumer (BER checker or descrambler).

## Interface
- `SCALE`, 65536: unit amplitude of the ±1 constellation level in input LSBs.
- `PILOT_WORD`, 32'hF0F0_3C3C: pilot bit pattern, oldest bit at bit 31.
- `clk`, in, 1: single system clock (11.0592 MHz).
- `rst_n`, in, 1: asynchronous, active-low reset. Deassertion is synchronised externally.
- `mod_type`, in, 1: modulation type, 0 = QPSK, 1 = 16QAM.
- `sym_i`, in, 32: signed I sample.
- `sym_q`, in, 32: signed Q sample.
- `sym_valid`, in, 1: an I/Q symbol is present.
- `sym_ready`, out, 1: the block accepts the symbol this cycle.
- `bit_out`, out, 1: serial data bit.
- `bit_valid`, out, 1: `bit_out` is valid.
- `bit_ready`, in, 1: the consumer takes the bit this cycle.
- `frame_lock`, out, 1: pilot found; data is being emitted.
- `err_cnt`, out, 16: out-of-range symbol count. Present only with the macro (see Configuration).

## Operation
- Symbol handshake: a symbol transfers on `sym_valid && sym_ready`. Bit handshake: a bit transfers on `bit_valid && bit_ready`.
- Bits per symbol (BPS): 2 in QPSK, 4 in 16QAM.
- Slicing (signed compare, ties resolve upward):
  - QPSK, per axis: x >= 0 gives 1, otherwise 0.
  - 16QAM, per axis: x < -2·SCALE gives 00; -2·SCALE <= x < 0 gives 01; 0 <= x < 2·SCALE gives 11; x >= 2·SCALE gives 10.
- Symbol word:
  - QPSK = {I, Q}.
  - 16QAM = {I[1:0], Q[1:0]}.
  - The MSB is transmitted first.
- State machine:
  - HUNT (reset state):
    - `sym_ready` = 1.
    - Each accepted symbol shifts BPS bits into the 32-bit window `win`.
    - `fill` counts the bits shifted in and saturates at 32.
    - If after the shift `fill` == 32 and `win` == `PILOT_WORD`, go to DATA.
    - Otherwise stay in HUNT; no bits are emitted.
  - DATA:
    - Each accepted symbol loads the serialiser: a shift register plus a bit counter, 0..BPS-1.
    - `sym_ready` = !loaded || (`bit_valid` && `bit_ready` && last bit).
    - This allows back-to-back symbols with no bubble.
    - DATA persists until reset or a `mod_type` change.
- `mod_type` change (value differs from the registered copy):
  - Return to HUNT next cycle.
  - Clear `win`, `fill` and the serialiser, and deassert `bit_valid`.
  - Any partial symbol is discarded.
- Reset values:
  - `sym_ready` = 0 while `rst_n` is low, then 1 in HUNT.
  - `bit_out` = 0, `bit_valid` = 0, `frame_lock` = 0, `err_cnt` = 0.

## Timing
- The symbol accepted in the matching cycle N sets `frame_lock` at N+1.
- The next accepted symbol is the first data symbol.
- A data symbol accepted at cycle N presents its MSB on `bit_out` with `bit_valid` = 1 at N+1.
- Each further bit appears in the cycle after its predecessor's handshake.
- `bit_out` and `bit_valid` are held stable while `bit_ready` = 0.
- If `sym_valid` drops mid-frame, `bit_valid` falls after the last bit of the loaded symbol.
- Reset asserted mid-serialisation forces all outputs to their reset values immediately (asynchronously).

## Configuration
- `QAM_DEMAP_ERR_CNT_EN`.
  - Defined:
    - `err_cnt` increments by 1 on each accepted symbol with |I| > 4·SCALE or |Q| > 4·SCALE, in any state.
    - The count saturates at 16'hFFFF.
    - It is cleared only by reset.
  - Undefined: the `err_cnt` port and its logic are absent.

## Structure
- Package `qam_rx_pkg` holds:
  - The mode encodings (QPSK = 0, QAM16 = 1).
  - The function `bps(mod_type)`.
  - The 16QAM Gray level codes (00/01/11/10).
  - The default `PILOT_WORD`.
- Sub-module `qam_slicer`: combinational per-axis decision, taking one signed 32-bit input, `SCALE` and `mod_type`, and producing a 2-bit code. It is instantiated twice, for I and Q. The state machine, window and serialiser stay in the top.

## Test plan
- QPSK, `bit_ready` = 1:
  - Stimulus: 16 pilot symbols (±SCALE encoding 32'hF0F0_3C3C), then data symbols (+SCALE, -SCALE) and (-SCALE, +SCALE).
  - Response: `frame_lock` rises one cycle after the 16th pilot symbol; bits out are 1,0,0,1.
- 16QAM slicer boundaries:
  - Stimulus: I values -2·SCALE-1, -2·SCALE, -1, 0, 2·SCALE-1, 2·SCALE, with Q = 0.
  - Response: I codes 00, 01, 01, 11, 11, 10.
- 16QAM backpressure:
  - Stimulus: after lock, hold `bit_ready` = 0 for 5 cycles with `sym_valid` = 1.
  - Response: `sym_ready` stays 0 and `bit_out` is stable; once released, 4 bits per symbol are emitted with no gap between symbols.
- False pilot:
  - Stimulus: only 7 16QAM symbols of the pilot (`fill` = 28), then a mismatching symbol.
  - Response: no lock; a following full pilot still locks.
- Mid-frame events:
  - Stimulus: toggle `mod_type` after 2 of 4 bits have been emitted.
  - Response: `bit_valid` = 0 and `frame_lock` = 0 next cycle; relock requires a full pilot.
  - Stimulus: assert `rst_n` low mid-serialisation.
  - Response: all outputs at reset values immediately.
- With `QAM_DEMAP_ERR_CNT_EN`:
  - Stimulus: three symbols with I = 4·SCALE+1 and one with I = 4·SCALE.
  - Response: `err_cnt` = 3.
